invader_fleet: RTL and testbench
================================

# invader_fleet

Invader-grid controller for the space-invaders game, sitting beside the player stage and directly upstream of `score_logic`. It marches a ROWS×COLS invader formation across the screen once per movement period, reverses and descends at the playfield edges, and tests the player bullet against live invaders. Outputs are the fleet origin and alive bitmap for `vga_controller`, and a one-cycle `invader_collision` pulse for `score_logic`.

## Interface
- `ROWS`, 5: invader rows
- `COLS`, 11: invader columns
- `INV_W`, 16: invader width, px (≤ 32)
- `INV_H`, 8: invader height, px (≤ 16)
- `COL_SHIFT`, 5: log2 column pitch (32 px)
- `ROW_SHIFT`, 4: log2 row pitch (16 px)
- `X_START`, 64 / `Y_START`, 48: origin after reset or respawn
- `STEP_X`, 4 / `STEP_Y`, 8: horizontal step and descent, px
- `LEFT_BOUND`, 8 / `RIGHT_BOUND`, 632 / `BOTTOM_Y`, 400: playfield limits, px
- `MOVE_FRAMES`, 32: frames per step, fixed-speed mode

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-low reset
- `arst` in 1: debounced game-restart pulse; same effect as reset
- `frame` in 1: one-cycle pulse per video frame
- `bullet_valid` in 1: player bullet in flight
- `bullet_x`, `bullet_y` in 10: bullet pixel position
- `fleet_x`, `fleet_y` out 10: pixel position of the top-left of cell (0,0)
- `alive` out ROWS*COLS: bit r*COLS+c set means invader (r,c) is alive
- `anim` out 1: sprite frame select
- `invader_collision` out 1: one-cycle hit pulse
- `fleet_landed` out 1: level; an invader reached `BOTTOM_Y`
- `fleet_cleared` out 1: one-cycle pulse when the wave is destroyed

## Operation
**Reset values** (`rst`=0 or `arst`=1):
- `fleet_x`=X_START, `fleet_y`=Y_START
- `alive` all ones, `alive_cnt`=ROWS*COLS
- direction right, frame counter 0
- `anim`=0; all pulses 0; `fleet_landed`=0; hit lock clear

**Hit test** (each cycle that `bullet_valid`=1, the hit lock is clear and the fleet is not landed):
- dx = bullet_x − fleet_x, dy = bullet_y − fleet_y, 11-bit signed
- col = dx>>COL_SHIFT, row = dy>>ROW_SHIFT
- Hit requires all of: dx≥0, dy≥0, col<COLS, row<ROWS, dx[COL_SHIFT-1:0]<INV_W, dy[ROW_SHIFT-1:0]<INV_H, and the alive bit set.
- On a hit: clear the alive bit, decrement `alive_cnt`, pulse `invader_collision`, set the hit lock.
- The hit lock clears when `bullet_valid`=0, so there is at most one kill per bullet flight.

**FSM** (states MARCH, LANDED):
- MARCH: on `frame`, increment the frame counter. When it reaches the period, zero it and step.
- Period is MOVE_FRAMES, or the speed-up value described under Configuration.
- Step, moving right: if right_edge+STEP_X > RIGHT_BOUND, then `fleet_y`+=STEP_Y and reverse direction with x unchanged; otherwise `fleet_x`+=STEP_X.
- Step, moving left: the same rule against LEFT_BOUND.
- right_edge = fleet_x + (maxcol<<COL_SHIFT) + INV_W − 1, where maxcol and mincol are taken over alive columns.
- `anim` toggles on every step.
- After a descent, if fleet_y + (maxrow<<ROW_SHIFT) + INV_H ≥ BOTTOM_Y, go to LANDED.
- LANDED: `fleet_landed`=1, no movement, hit test disabled. Only reset or `arst` exits.

**Wave clear:**
- When `alive_cnt` reaches 0, pulse `fleet_cleared` the cycle after the killing hit.
- On the next `frame`, respawn with reset values, except that any hit lock in progress is kept.

## Timing
- `invader_collision` and the alive-bit clear are registered one cycle after the sampled bullet.
- Step updates appear on the edge following the qualifying `frame`.
- A hit and a step in the same cycle: the hit test uses pre-step registered position; both take effect.
- The kill of the last invader in the same cycle as a step: the step applies; respawn waits for the next `frame`.
- `arst` asserted mid-operation reinitialises everything in one cycle.

## Configuration
- `FLEET_SPEEDUP_EN` defined: period = (alive_cnt>>1)+1 frames, recomputed at each step.
  - Example: 55 alive gives 28; 1 alive gives 1.
- `FLEET_SPEEDUP_EN` not defined: period = MOVE_FRAMES always.

## Structure
- Screen bounds and the fleet pitch/size constants belong in the shared `constants.v`.
- Sub-module `fleet_extents`: combinational. Input is `alive`; outputs are mincol, maxcol and maxrow via priority encoders over column/row OR-reductions.
- The FSM, position registers, counters and hit logic stay in `invader_fleet`.

## Test plan
All scenarios use default parameters.
- Reset release: `fleet_x`=64, `fleet_y`=48, `alive`=all ones, `anim`=0, all pulses 0.
- Bullet (162,83) held valid for 20 cycles: one `invader_collision` pulse one cycle later; bit 25 (row 2, col 3) clears; no second pulse.
- Bullet (84,50), which is in the column gap: no collision and `alive` is unchanged.
- `FLEET_SPEEDUP_EN` off, 32 frames: `fleet_x`=68, `anim`=1. After 58 steps `fleet_x`=296. Next step: `fleet_y`=56, direction left, x unchanged.
- Kill all of column 10, then march: reversal occurs after 66 right steps (`fleet_x`=328).
- Kill the last live invader: `fleet_cleared` pulses once; at the next `frame` the fleet respawns at (64,48) with all alive.

Source files
------------

// File: rtl/invader_fleet_pkg.sv
// invader_fleet shared constants and types.
// FLEET_SPEEDUP_EN selects the alive-count-driven march period.
package invader_fleet_pkg;

  localparam int ROWS        = 5;
  localparam int COLS        = 11;
  localparam int INV_W       = 16;
  localparam int INV_H       = 8;
  localparam int COL_SHIFT   = 5;
  localparam int ROW_SHIFT   = 4;
  localparam int X_START     = 64;
  localparam int Y_START     = 48;
  localparam int STEP_X      = 4;
  localparam int STEP_Y      = 8;
  localparam int LEFT_BOUND  = 8;
  localparam int RIGHT_BOUND = 632;
  localparam int BOTTOM_Y    = 400;
  localparam int MOVE_FRAMES = 32;

  localparam int NINV  = ROWS * COLS;
  localparam int CNT_W = $clog2(NINV + 1);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int FC_W  = 6;

`ifdef FLEET_SPEEDUP_EN
  localparam int PERIOD_INIT = NINV / 2 + 1;
`else
  localparam int PERIOD_INIT = MOVE_FRAMES;
`endif

  typedef enum logic {
    ST_MARCH,
    ST_LANDED
  } state_e;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_e;

endpackage

// File: rtl/invader_fleet_if.sv
// Game-side bus of the invader fleet: frame tick, bullet in,
// fleet position/bitmap and event pulses out.
interface invader_fleet_if;
  import invader_fleet_pkg::*;

  logic            frame;
  logic            bullet_valid;
  logic [9:0]      bullet_x;
  logic [9:0]      bullet_y;
  logic [9:0]      fleet_x;
  logic [9:0]      fleet_y;
  logic [NINV-1:0] alive;
  logic            anim;
  logic            invader_collision;
  logic            fleet_landed;
  logic            fleet_cleared;

  modport master (
    output frame, bullet_valid, bullet_x, bullet_y,
    input  fleet_x, fleet_y, alive, anim,
    input  invader_collision, fleet_landed, fleet_cleared
  );

  modport slave (
    input  frame, bullet_valid, bullet_x, bullet_y,
    output fleet_x, fleet_y, alive, anim,
    output invader_collision, fleet_landed, fleet_cleared
  );

endinterface

// File: rtl/invader_fleet_extents.sv
// fleet_extents: leftmost/rightmost live column and lowest
// live row of the formation, purely combinational.
module fleet_extents
  import invader_fleet_pkg::*;
(
  input  logic [NINV-1:0]  alive_i,
  output logic [COL_W-1:0] mincol_o,
  output logic [COL_W-1:0] maxcol_o,
  output logic [ROW_W-1:0] maxrow_o
);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_any[c] = col_any[c] | alive_i[r*COLS+c];
        row_any[r] = row_any[r] | alive_i[r*COLS+c];
      end
    end
  end

  always_comb begin
    mincol_o = '0;
    maxcol_o = '0;
    maxrow_o = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (col_any[c]) mincol_o = COL_W'(c);
    for (int c = 0; c < COLS; c++)
      if (col_any[c]) maxcol_o = COL_W'(c);
    for (int r = 0; r < ROWS; r++)
      if (row_any[r]) maxrow_o = ROW_W'(r);
  end

endmodule

// File: rtl/invader_fleet.sv
// Invader formation: march/descend FSM, bullet hit test, wave respawn.
// Define FLEET_SPEEDUP_EN to shorten the march period as invaders die.
module invader_fleet
  import invader_fleet_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic arst,
  invader_fleet_if.slave bus
);

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [NINV-1:0] alive_q, alive_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [FC_W-1:0] period_q, period_d;
  logic            anim_q, anim_d;
  logic            coll_q, coll_d;
  logic            clr_q, clr_d;
  logic            lock_q, lock_d;

  logic [COL_W-1:0] mincol, maxcol;
  logic [ROW_W-1:0] maxrow;

  fleet_extents u_ext (
    .alive_i  (alive_q),
    .mincol_o (mincol),
    .maxcol_o (maxcol),
    .maxrow_o (maxrow)
  );

  logic [10:0]      dx, dy, col_f, row_f;
  logic [CNT_W-1:0] hit_idx;
  logic             in_cell, hit;

  assign dx    = {1'b0, bus.bullet_x} - {1'b0, x_q};
  assign dy    = {1'b0, bus.bullet_y} - {1'b0, y_q};
  assign col_f = dx >> COL_SHIFT;
  assign row_f = dy >> ROW_SHIFT;

  assign in_cell = !dx[10] && !dy[10]
    && (col_f < 11'(COLS)) && (row_f < 11'(ROWS))
    && ({1'b0, dx[COL_SHIFT-1:0]} < (COL_SHIFT+1)'(INV_W))
    && ({1'b0, dy[ROW_SHIFT-1:0]} < (ROW_SHIFT+1)'(INV_H));

  assign hit_idx = CNT_W'(row_f[ROW_W-1:0]) * CNT_W'(COLS)
                 + CNT_W'(col_f[COL_W-1:0]);

  assign hit = bus.bullet_valid && !lock_q
    && (state_q == ST_MARCH) && in_cell && alive_q[hit_idx];

  logic [11:0] rx, lx, land_y;
  logic [9:0]  y_desc;
  logic        at_edge, landing;

  assign rx = 12'(x_q) + (12'(maxcol) << COL_SHIFT)
            + 12'(INV_W - 1);
  assign lx = 12'(x_q) + (12'(mincol) << COL_SHIFT);
  assign at_edge = (dir_q == DIR_RIGHT)
    ? (rx + 12'(STEP_X) > 12'(RIGHT_BOUND))
    : (lx < 12'(LEFT_BOUND + STEP_X));
  assign y_desc  = y_q + 10'(STEP_Y);
  assign land_y  = 12'(y_desc) + (12'(maxrow) << ROW_SHIFT)
                 + 12'(INV_H);
  assign landing = land_y >= 12'(BOTTOM_Y);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    alive_d  = alive_q;
    cnt_d    = cnt_q;
    fc_d     = fc_q;
    period_d = period_q;
    anim_d   = anim_q;
    coll_d   = hit;
    clr_d    = coll_q && (cnt_q == '0);
    lock_d   = bus.bullet_valid && (lock_q || hit);

    unique case (state_q)
      ST_MARCH: begin
        if (bus.frame && cnt_q == '0) begin
          // wave gone: fresh formation, bullet lock untouched
          x_d      = 10'(X_START);
          y_d      = 10'(Y_START);
          alive_d  = '1;
          cnt_d    = CNT_W'(NINV);
          dir_d    = DIR_RIGHT;
          fc_d     = '0;
          anim_d   = 1'b0;
          period_d = FC_W'(PERIOD_INIT);
        end else if (bus.frame) begin
          if (fc_q + FC_W'(1) >= period_q) begin
            fc_d   = '0;
            anim_d = ~anim_q;
`ifdef FLEET_SPEEDUP_EN
            period_d = FC_W'(cnt_q >> 1) + FC_W'(1);
`endif
            if (at_edge) begin
              y_d   = y_desc;
              dir_d = (dir_q == DIR_RIGHT) ? DIR_LEFT
                                           : DIR_RIGHT;
              if (landing) state_d = ST_LANDED;
            end else if (dir_q == DIR_RIGHT) begin
              x_d = x_q + 10'(STEP_X);
            end else begin
              x_d = x_q - 10'(STEP_X);
            end
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
      end
      ST_LANDED: begin
      end
    endcase

    if (hit) begin
      alive_d[hit_idx] = 1'b0;
      cnt_d            = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || arst) begin
      state_q  <= ST_MARCH;
      dir_q    <= DIR_RIGHT;
      x_q      <= 10'(X_START);
      y_q      <= 10'(Y_START);
      alive_q  <= '1;
      cnt_q    <= CNT_W'(NINV);
      fc_q     <= '0;
      period_q <= FC_W'(PERIOD_INIT);
      anim_q   <= 1'b0;
      coll_q   <= 1'b0;
      clr_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      alive_q  <= alive_d;
      cnt_q    <= cnt_d;
      fc_q     <= fc_d;
      period_q <= period_d;
      anim_q   <= anim_d;
      coll_q   <= coll_d;
      clr_q    <= clr_d;
      lock_q   <= lock_d;
    end
  end

  assign bus.fleet_x           = x_q;
  assign bus.fleet_y           = y_q;
  assign bus.alive             = alive_q;
  assign bus.anim              = anim_q;
  assign bus.invader_collision = coll_q;
  assign bus.fleet_landed      = (state_q == ST_LANDED);
  assign bus.fleet_cleared     = clr_q;

endmodule

// File: tb/tb_invader_fleet.sv
// Bench for invader_fleet: directed scenarios plus random traffic
// checked against a rectangle-level model of the formation.
module tb_invader_fleet;
  import invader_fleet_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  invader_fleet_if bus();

  invader_fleet dut (
    .clk  (clk),
    .rst  (rst),
    .arst (arst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_coll = 0;
  int n_clr = 0;

  always @(negedge clk) begin
    if (bus.invader_collision === 1'b1) n_coll++;
    if (bus.fleet_cleared === 1'b1) n_clr++;
  end

  // model state
  int mx, my, mcnt, mfc, mperiod, msteps;
  bit mright, manim, mlanded, mlock, mcoll, mclr, mpend;
  bit [NINV-1:0] malive;

  task automatic model_respawn();
    mx = X_START;
    my = Y_START;
    malive = '1;
    mcnt = NINV;
    mright = 1;
    mfc = 0;
    manim = 0;
`ifdef FLEET_SPEEDUP_EN
    mperiod = NINV / 2 + 1;
`else
    mperiod = MOVE_FRAMES;
`endif
  endtask

  task automatic model_reset();
    model_respawn();
    mlanded = 0;
    mlock = 0;
    mcoll = 0;
    mclr = 0;
    mpend = 0;
  endtask

  task automatic model_step();
    int minc, maxc, maxr;
    bit edge_hit;
    minc = COLS;
    maxc = -1;
    maxr = -1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (malive[r*COLS+c]) begin
          if (c < minc) minc = c;
          if (c > maxc) maxc = c;
          if (r > maxr) maxr = r;
        end
`ifdef FLEET_SPEEDUP_EN
    mperiod = mcnt / 2 + 1;
`endif
    manim = !manim;
    msteps++;
    if (mright)
      edge_hit = mx + maxc*32 + INV_W - 1 + STEP_X > RIGHT_BOUND;
    else
      edge_hit = mx + minc*32 - STEP_X < LEFT_BOUND;
    if (edge_hit) begin
      my += STEP_Y;
      mright = !mright;
      if (my + maxr*16 + INV_H >= BOTTOM_Y) mlanded = 1;
    end else begin
      mx += mright ? STEP_X : -STEP_X;
    end
  endtask

  task automatic model_update();
    int bx, by, hr, hc;
    bit hit, clr_n, lock_n;
    if (!rst || arst) begin
      model_reset();
      return;
    end
    bx = int'(bus.bullet_x);
    by = int'(bus.bullet_y);
    hit = 0;
    hr = 0;
    hc = 0;
    if (bus.bullet_valid && !mlock && !mlanded)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (malive[r*COLS+c]
              && bx >= mx + c*32 && bx < mx + c*32 + INV_W
              && by >= my + r*16 && by < my + r*16 + INV_H) begin
            hit = 1;
            hr = r;
            hc = c;
          end
    clr_n = mpend;
    mpend = hit && mcnt == 1;
    lock_n = bus.bullet_valid && (mlock || hit);
    if (!mlanded && bus.frame) begin
      if (mcnt == 0) model_respawn();
      else begin
        mfc++;
        if (mfc >= mperiod) begin
          mfc = 0;
          model_step();
        end
      end
    end
    if (hit) begin
      malive[hr*COLS+hc] = 0;
      mcnt--;
    end
    mcoll = hit;
    mclr = clr_n;
    mlock = lock_n;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    bus.frame = 0;
    bus.bullet_valid = 0;
    arst = 0;
    rst = 0;
    cycle();
    cycle();
    rst = 1;
  endtask

  task automatic do_step();
    int s0 = msteps;
    for (int k = 0; k < 300 && msteps == s0; k++) begin
      bus.frame = 1;
      cycle();
      bus.frame = 0;
      cycle();
    end
    if (msteps == s0) begin
      n_chk++;
      n_fail++;
      $display("FAIL step_timeout no step seen");
    end
  endtask

  task automatic kill(input int r, input int c);
    bus.bullet_x = 10'(mx + c*32 + int'($urandom_range(0, 15)));
    bus.bullet_y = 10'(my + r*16 + int'($urandom_range(0, 7)));
    bus.bullet_valid = 1;
    cycle();
    cycle();
    bus.bullet_valid = 0;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (bus.fleet_x !== 10'd64 || bus.fleet_y !== 10'd48) begin
      n_fail++;
      $display("FAIL reset_pos got %0d,%0d exp 64,48",
               bus.fleet_x, bus.fleet_y);
    end
    n_chk++;
    if (bus.alive !== {NINV{1'b1}}) begin
      n_fail++;
      $display("FAIL reset_alive got %h", bus.alive);
    end
    n_chk++;
    if ({bus.anim, bus.invader_collision, bus.fleet_landed,
         bus.fleet_cleared} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000",
               {bus.anim, bus.invader_collision,
                bus.fleet_landed, bus.fleet_cleared});
    end
  endtask

  task automatic test_hit();
    int pulses = 0;
    int first = -1;
    logic [NINV-1:0] exp_alive;
    do_reset();
    bus.bullet_x = 10'd162;
    bus.bullet_y = 10'd83;
    bus.bullet_valid = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.invader_collision === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    bus.bullet_valid = 0;
    cycle();
    n_chk++;
    if (pulses != 1 || first != 0) begin
      n_fail++;
      $display("FAIL hit_pulse got %0d at %0d exp 1 at 0",
               pulses, first);
    end
    exp_alive = '1;
    exp_alive[25] = 1'b0;
    n_chk++;
    if (bus.alive !== exp_alive) begin
      n_fail++;
      $display("FAIL hit_alive got %h exp %h",
               bus.alive, exp_alive);
    end
  endtask

  task automatic test_gap();
    int c0;
    do_reset();
    c0 = n_coll;
    bus.bullet_x = 10'd84;
    bus.bullet_y = 10'd50;
    bus.bullet_valid = 1;
    repeat (5) cycle();
    bus.bullet_valid = 0;
    cycle();
    n_chk++;
    if (n_coll != c0 || bus.alive !== {NINV{1'b1}}) begin
      n_fail++;
      $display("FAIL gap got pulses=%0d alive=%h exp 0 all-ones",
               n_coll - c0, bus.alive);
    end
  endtask

  task automatic test_march();
    do_reset();
    do_step();
    n_chk++;
    if (bus.fleet_x !== 10'd68 || bus.anim !== 1'b1) begin
      n_fail++;
      $display("FAIL march1 got x=%0d anim=%b exp 68 1",
               bus.fleet_x, bus.anim);
    end
    repeat (57) do_step();
    n_chk++;
    if (bus.fleet_x !== 10'd296 || bus.fleet_y !== 10'd48) begin
      n_fail++;
      $display("FAIL march58 got %0d,%0d exp 296,48",
               bus.fleet_x, bus.fleet_y);
    end
    do_step();
    n_chk++;
    if (bus.fleet_x !== 10'd296 || bus.fleet_y !== 10'd56) begin
      n_fail++;
      $display("FAIL descend got %0d,%0d exp 296,56",
               bus.fleet_x, bus.fleet_y);
    end
    do_step();
    n_chk++;
    if (bus.fleet_x !== 10'd292 || bus.anim !== 1'b0) begin
      n_fail++;
      $display("FAIL leftstep got x=%0d anim=%b exp 292 0",
               bus.fleet_x, bus.anim);
    end
  endtask

  task automatic test_arst();
    kill(0, 0);
    arst = 1;
    cycle();
    arst = 0;
    n_chk++;
    if (bus.fleet_x !== 10'd64 || bus.fleet_y !== 10'd48
        || bus.alive !== {NINV{1'b1}} || bus.anim !== 1'b0) begin
      n_fail++;
      $display("FAIL arst got %0d,%0d alive=%h anim=%b",
               bus.fleet_x, bus.fleet_y, bus.alive, bus.anim);
    end
  endtask

  task automatic test_col10();
    logic [NINV-1:0] exp_alive;
    int c0;
    do_reset();
    c0 = n_coll;
    for (int r = 0; r < ROWS; r++) kill(r, 10);
    exp_alive = '1;
    for (int r = 0; r < ROWS; r++) exp_alive[r*COLS+10] = 1'b0;
    n_chk++;
    if (bus.alive !== exp_alive || n_coll - c0 != 5) begin
      n_fail++;
      $display("FAIL col10_kill got %h pulses=%0d exp %h 5",
               bus.alive, n_coll - c0, exp_alive);
    end
    repeat (66) do_step();
    n_chk++;
    if (bus.fleet_x !== 10'd328 || bus.fleet_y !== 10'd48) begin
      n_fail++;
      $display("FAIL col10_march got %0d,%0d exp 328,48",
               bus.fleet_x, bus.fleet_y);
    end
    do_step();
    n_chk++;
    if (bus.fleet_x !== 10'd328 || bus.fleet_y !== 10'd56) begin
      n_fail++;
      $display("FAIL col10_rev got %0d,%0d exp 328,56",
               bus.fleet_x, bus.fleet_y);
    end
  endtask

  task automatic test_clear();
    int c0, k0;
    do_reset();
    c0 = n_coll;
    k0 = n_clr;
    for (int i = 0; i < NINV - 1; i++) kill(i / COLS, i % COLS);
    n_chk++;
    if (n_clr != k0) begin
      n_fail++;
      $display("FAIL clear_early got %0d exp 0", n_clr - k0);
    end
    kill(ROWS - 1, COLS - 1);
    repeat (3) cycle();
    n_chk++;
    if (n_coll - c0 != NINV || n_clr - k0 != 1
        || bus.alive !== '0) begin
      n_fail++;
      $display("FAIL clear got kills=%0d clr=%0d alive=%h",
               n_coll - c0, n_clr - k0, bus.alive);
    end
    bus.frame = 1;
    cycle();
    bus.frame = 0;
    cycle();
    n_chk++;
    if (bus.fleet_x !== 10'd64 || bus.fleet_y !== 10'd48
        || bus.alive !== {NINV{1'b1}} || n_clr - k0 != 1) begin
      n_fail++;
      $display("FAIL respawn got %0d,%0d alive=%h clr=%0d",
               bus.fleet_x, bus.fleet_y, bus.alive, n_clr - k0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.frame = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0)
        bus.bullet_valid = !bus.bullet_valid;
      if ($urandom_range(0, 1) == 0) begin
        bus.bullet_x = 10'(mx + int'($urandom_range(0, 10))*32
                           + int'($urandom_range(0, 20)));
        bus.bullet_y = 10'(my + int'($urandom_range(0, 4))*16
                           + int'($urandom_range(0, 9)));
      end else begin
        bus.bullet_x = 10'($urandom_range(0, 639));
        bus.bullet_y = 10'($urandom_range(0, 479));
      end
      arst = ($urandom_range(0, 699) == 0);
      cycle();
      n_chk++;
      if (bus.fleet_x !== 10'(mx) || bus.fleet_y !== 10'(my)) begin
        n_fail++;
        $display("FAIL rnd_pos cyc %0d got %0d,%0d exp %0d,%0d",
                 i, bus.fleet_x, bus.fleet_y, mx, my);
      end
      n_chk++;
      if (bus.alive !== malive) begin
        n_fail++;
        $display("FAIL rnd_alive cyc %0d got %h exp %h",
                 i, bus.alive, malive);
      end
      n_chk++;
      if ({bus.anim, bus.invader_collision, bus.fleet_landed,
           bus.fleet_cleared} !== {manim, mcoll, mlanded, mclr}) begin
        n_fail++;
        $display("FAIL rnd_flags cyc %0d got %b exp %b", i,
                 {bus.anim, bus.invader_collision,
                  bus.fleet_landed, bus.fleet_cleared},
                 {manim, mcoll, mlanded, mclr});
      end
    end
    arst = 0;
    bus.frame = 0;
    bus.bullet_valid = 0;
  endtask

  initial begin
    bus.frame = 0;
    bus.bullet_valid = 0;
    bus.bullet_x = '0;
    bus.bullet_y = '0;
    msteps = 0;
    model_reset();
    test_reset();
    test_hit();
    test_gap();
    test_march();
    test_arst();
    test_col10();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
